seven_seg_scanner: RTL and testbench

Time-multiplexed driver for the 4-digit common-anode seven-segment display on the lab board. It takes four BCD digits plus per-digit enables and decimal points. It cycles one digit at a time onto the shared seg/dp lines and drives the matching anode, so all four digits appear lit. It sits between the lab top-level I/O wrapper (switches/counters upstream) and the board pins, and replaces the fixed single-anode hookup used in earlier labs.

---
 rtl/seven_seg_scanner_pkg.sv | 25 ++
 rtl/seven_seg_scanner_if.sv | 23 ++
 rtl/seven_seg_scanner_decoder.sv | 29 ++
 rtl/seven_seg_scanner.sv | 112 +++++++++++
 tb/tb_seven_seg_scanner.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_scanner_pkg.sv
// Shared display definitions for the lab seven-segment scanner.
package seven_seg_scanner_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  // Segment bit positions, a..g, seg[0] = a.
  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  // Active-low idle patterns on the board pins.
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  // Per-slot phase: anodes dark first, then the digit is driven.
  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Digit inputs and display pin outputs of the scanner.
interface seven_seg_scanner_if;
  logic [15:0] digits;
  logic [3:0]  digit_en;
  logic [3:0]  dp_in;
  logic        suppress_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  slot_idx;

  // master: the block supplying digits (I/O wrapper or bench)
  modport master (
    output digits, digit_en, dp_in, suppress_lz,
    input  seg, dp, an, slot_idx
  );

  // slave: the scanner itself
  modport slave (
    input  digits, digit_en, dp_in, suppress_lz,
    output seg, dp, an, slot_idx
  );
endinterface

// File: rtl/seven_seg_scanner_decoder.sv
// BCD to seven-segment decoder, active-high segments, a..g in bits 0..6.
// Values 10..15 and display_on=0 give all segments off.
module svn_seg_decoder (
  input  logic       display_on,
  input  logic [3:0] bcd_in,
  output logic [6:0] seg_out
);

  // Pure lookup; no state.
  always_comb begin
    seg_out = 7'b0000000;
    if (display_on) begin
      case (bcd_in)
        4'd0:    seg_out = 7'b0111111;
        4'd1:    seg_out = 7'b0000110;
        4'd2:    seg_out = 7'b1011011;
        4'd3:    seg_out = 7'b1001111;
        4'd4:    seg_out = 7'b1100110;
        4'd5:    seg_out = 7'b1101101;
        4'd6:    seg_out = 7'b1111101;
        4'd7:    seg_out = 7'b0000111;
        4'd8:    seg_out = 7'b1111111;
        4'd9:    seg_out = 7'b1101111;
        default: seg_out = 7'b0000000;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Each slot lasts DIGIT_CYCLES clocks: BLANK_CYCLES dark, then the digit.
// Inputs are snapshotted at every slot boundary; all outputs are registered.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                clk,
  input  logic                rst,
  seven_seg_scanner_if.slave  bus
);

  localparam int unsigned CNT_W    = $clog2(DIGIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       slot_q, slot_d;
  phase_e           phase_q, phase_d;

  logic [15:0]      snap_digits_q, snap_digits_d;
  logic [3:0]       snap_en_q, snap_en_d;
  logic [3:0]       snap_dp_q, snap_dp_d;
  logic             snap_sup_q, snap_sup_d;

  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [3:0]       an_q, an_d;

  logic [3:0]       lz_blank;
  logic [3:0]       visible;
  logic             show;
  logic [3:0]       bcd_sel;
  logic [6:0]       dec_seg;

  // Leading-zero blanking and visibility, from the snapshot only.
  always_comb begin
    lz_blank    = '0;
    lz_blank[3] = snap_sup_q & (snap_digits_q[15:12] == 4'd0);
    lz_blank[2] = lz_blank[3] & (snap_digits_q[11:8] == 4'd0);
    lz_blank[1] = lz_blank[2] & (snap_digits_q[7:4] == 4'd0);
    visible     = snap_en_q & ~lz_blank;
    show        = visible[slot_q] & (phase_q == PH_DRIVE);
    bcd_sel     = snap_digits_q[{slot_q, 2'b00} +: 4];
  end

  svn_seg_decoder u_decoder (
    .display_on (show),
    .bcd_in     (bcd_sel),
    .seg_out    (dec_seg)
  );

  // Next-state: counter, slot, snapshot, phase and decoded pin values.
  // Phase is derived from the next count so phase_q always matches cnt_q.
  always_comb begin
    cnt_d         = cnt_q;
    slot_d        = slot_q;
    snap_digits_d = snap_digits_q;
    snap_en_d     = snap_en_q;
    snap_dp_d     = snap_dp_q;
    snap_sup_d    = snap_sup_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d         = '0;
      slot_d        = slot_q + 2'd1;
      snap_digits_d = bus.digits;
      snap_en_d     = bus.digit_en;
      snap_dp_d     = bus.dp_in;
      snap_sup_d    = bus.suppress_lz;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    phase_d = (32'(cnt_d) >= BLANK_CYCLES) ? PH_DRIVE : PH_BLANK;

    seg_d = ~dec_seg;
    an_d  = show ? ~(4'b0001 << slot_q) : AN_OFF;
    dp_d  = show ? ~snap_dp_q[slot_q] : 1'b1;
  end

  // Single state/output register bank with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      slot_q        <= '0;
      phase_q       <= (BLANK_CYCLES == 0) ? PH_DRIVE : PH_BLANK;
      snap_digits_q <= '0;
      snap_en_q     <= '0;
      snap_dp_q     <= '0;
      snap_sup_q    <= 1'b0;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
      an_q          <= AN_OFF;
    end else begin
      cnt_q         <= cnt_d;
      slot_q        <= slot_d;
      phase_q       <= phase_d;
      snap_digits_q <= snap_digits_d;
      snap_en_q     <= snap_en_d;
      snap_dp_q     <= snap_dp_d;
      snap_sup_q    <= snap_sup_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
    end
  end

  assign bus.seg      = seg_q;
  assign bus.dp       = dp_q;
  assign bus.an       = an_q;
  assign bus.slot_idx = slot_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: directed scenarios plus random
// input changes and resets, compared cycle by cycle against a reference model.
module tb_seven_seg_scanner;

  localparam int unsigned DC = 8;
  localparam int unsigned BC = 2;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  seven_seg_scanner_if bus_if ();

  seven_seg_scanner #(
    .DIGIT_CYCLES (DC),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: position in the scan and the captured inputs.
  int          m_cnt;
  int          m_slot;
  logic [15:0] m_digits;
  logic [3:0]  m_en;
  logic [3:0]  m_dp;
  logic        m_sup;

  // Active-low glyphs for 0..9; anything else is dark.
  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] t [10];
    t[0] = 7'b1000000; t[1] = 7'b1111001; t[2] = 7'b0100100; t[3] = 7'b0110000;
    t[4] = 7'b0011001; t[5] = 7'b0010010; t[6] = 7'b0000010; t[7] = 7'b1111000;
    t[8] = 7'b0000000; t[9] = 7'b0010000;
    if (v < 4'd10) return t[v];
    return 7'b1111111;
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: predict the registered outputs from the pre-edge model
  // state, advance the model, then compare after the edge.
  task automatic tick();
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic       e_dp;
    logic [3:0] d;
    bit         lit;
    e_seg = 7'b1111111;
    e_an  = 4'b1111;
    e_dp  = 1'b1;
    if (rst) begin
      m_cnt = 0; m_slot = 0;
      m_digits = '0; m_en = '0; m_dp = '0; m_sup = 1'b0;
    end else begin
      d = 4'((m_digits >> (4 * m_slot)) & 16'hF);
      // Digit i>0 is a leading zero when it and everything above it is zero.
      lit = m_en[m_slot] && !(m_sup && m_slot > 0 && (m_digits >> (4 * m_slot)) == 0);
      if (m_cnt >= int'(BC) && lit) begin
        e_seg = glyph(d);
        e_an  = ~(4'b0001 << m_slot);
        e_dp  = ~m_dp[m_slot];
      end
      if (m_cnt == int'(DC) - 1) begin
        m_cnt = 0;
        m_slot = (m_slot + 1) % 4;
        m_digits = bus_if.digits; m_en = bus_if.digit_en;
        m_dp = bus_if.dp_in;      m_sup = bus_if.suppress_lz;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    check_eq("seg", 16'(bus_if.seg), 16'(e_seg));
    check_eq("an", 16'(bus_if.an), 16'(e_an));
    check_eq("dp", 16'(bus_if.dp), 16'(e_dp));
    check_eq("slot_idx", 16'(bus_if.slot_idx), 16'(m_slot));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_in(input logic [15:0] dg, input logic [3:0] en,
                        input logic [3:0] dpi, input logic sup);
    bus_if.digits = dg; bus_if.digit_en = en;
    bus_if.dp_in = dpi; bus_if.suppress_lz = sup;
  endtask

  int drive_seen;
  int bad_an;

  initial begin
    checks = 0; failures = 0;
    m_cnt = 0; m_slot = 0; m_digits = '0; m_en = '0; m_dp = '0; m_sup = 1'b0;
    rst = 1'b1;
    set_in(16'h1234, 4'hF, 4'h0, 1'b0);

    // Reset hold, then first DRIVE of slot0 on the third edge after release.
    run(3);
    check_eq("rst_an", 16'(bus_if.an), 16'hF);
    check_eq("rst_seg", 16'(bus_if.seg), 16'h7F);
    rst = 1'b0;
    run(40);

    // 1234 scanning: anode 1110 must carry "4".
    drive_seen = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (bus_if.an == 4'b1110) begin
        drive_seen++;
        check_eq("s2_digit0_4", 16'(bus_if.seg), 16'h19);
      end
    end
    check_eq("s2_drive_cycles", 16'(drive_seen), 16'd12);

    // Leading-zero suppression on and off.
    set_in(16'h0070, 4'hF, 4'h0, 1'b1);
    run(72);
    set_in(16'h0070, 4'hF, 4'h0, 1'b0);
    run(72);

    // Mid-slot change must wait for the next boundary.
    set_in(16'h1111, 4'hF, 4'h0, 1'b0);
    run(40);
    for (int i = 0; i < 64 && !(m_slot == 1 && m_cnt == 4); i++) tick();
    check_eq("s4_sync_slot", 16'(bus_if.slot_idx), 16'd1);
    set_in(16'h2222, 4'hF, 4'h0, 1'b0);
    run(64);

    // Only digits 1 and 3 enabled, all dps requested.
    set_in(16'h5678, 4'b1010, 4'hF, 1'b0);
    bad_an = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (i >= 40 && bus_if.an != 4'b1101 && bus_if.an != 4'b0111 && bus_if.an != 4'b1111)
        bad_an++;
    end
    check_eq("s5_bad_anodes", 16'(bad_an), 16'd0);

    // Non-BCD digit, then reset in slot2 at cnt 5.
    set_in(16'h000B, 4'hF, 4'h0, 1'b0);
    run(40);
    for (int i = 0; i < 64 && !(m_slot == 2 && m_cnt == 5); i++) tick();
    check_eq("s6_sync_slot", 16'(bus_if.slot_idx), 16'd2);
    rst = 1'b1;
    tick();
    check_eq("s6_rst_slot", 16'(bus_if.slot_idx), 16'd0);
    check_eq("s6_rst_an", 16'(bus_if.an), 16'hF);
    rst = 1'b0;
    run(40);

    // Random inputs changed at random times, occasional reset pulses.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(5, 0) == 0)
        set_in(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
      if ($urandom_range(15, 0) < 4 && $urandom_range(1, 0) == 0)
        bus_if.digits = 16'($urandom_range(9, 0)) << (4 * $urandom_range(3, 0));
      rst = ($urandom_range(199, 0) == 0);
      tick();
    end
    rst = 1'b0;
    run(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
